// File: rtl/demux_nto2n_stream.sv
// demux_nto2n_stream
//   Streaming 1-to-2 demultiplexer. One N-bit word per cycle is accepted on a
//   valid/ready input and steered by S (sampled with the word) into one of two
//   2-entry FIFOs. Each FIFO drives its own valid/ready output channel. A
//   stalled consumer therefore only blocks words addressed to its own output.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   I, S, I_valid       input word, destination select (0 -> O0, 1 -> O1), valid
//   I_ready             FIFO[S] not full (held low during reset)
//   O0/O1, Ok_valid     head-of-FIFO data and presence per output
//   O0_ready/O1_ready   consumer accepts head word
//   count0/count1       words delivered per output, modulo 2^CW
//   busy                at least one output FIFO holds a word
module demux_nto2n_stream #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  I,
  input  logic          S,
  input  logic          I_valid,
  output logic          I_ready,
  output logic [N-1:0]  O0,
  output logic          O0_valid,
  input  logic          O0_ready,
  output logic [N-1:0]  O1,
  output logic          O1_valid,
  input  logic          O1_ready,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1,
  output logic          busy
);

  logic [1:0]    out_ready;
  logic [1:0]    full;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    head_valid;
  logic [N-1:0]  head [2];
  logic [CW-1:0] cnt  [2];

  assign out_ready = {O1_ready, O0_ready};

  // Only the addressed FIFO gates acceptance; a full FIFO refuses input even
  // if it is being popped on the same edge.
  assign I_ready = !rst && !full[S];
  assign push    = (I_valid && I_ready) ? {S, !S} : 2'b00;
  assign pop     = head_valid & out_ready;

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [N-1:0]  mem [2];
    logic          wptr;
    logic          rptr;
    logic [1:0]    occ;
    logic [CW-1:0] dcnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        // Storage is cleared too so discarded words can never resurface on Ok.
        mem[0] <= '0;
        mem[1] <= '0;
        wptr   <= 1'b0;
        rptr   <= 1'b0;
        occ    <= '0;
        dcnt   <= '0;
      end else begin
        if (push[k]) begin
          mem[wptr] <= I;
          wptr      <= ~wptr;
        end
        if (pop[k]) begin
          rptr <= ~rptr;
          dcnt <= dcnt + 1'b1;
        end
        if (push[k] && !pop[k]) begin
          occ <= occ + 2'd1;
        end else if (!push[k] && pop[k]) begin
          occ <= occ - 2'd1;
        end
      end
    end

    assign head[k]       = mem[rptr];
    assign head_valid[k] = (occ != 2'd0);
    assign full[k]       = (occ == 2'd2);
    assign cnt[k]        = dcnt;
  end

  assign O0       = head[0];
  assign O1       = head[1];
  assign O0_valid = head_valid[0];
  assign O1_valid = head_valid[1];
  assign count0   = cnt[0];
  assign count1   = cnt[1];
  assign busy     = head_valid[0] | head_valid[1];

endmodule

// File: tb/tb_demux_nto2n_stream.sv
// Directed testbench for demux_nto2n_stream (N=32, CW=4 so the delivered-word
// counter wrap is reachable in a short run).
module tb_demux_nto2n_stream;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  I;
  logic          S;
  logic          I_valid;
  logic          I_ready;
  logic [N-1:0]  O0;
  logic          O0_valid;
  logic          O0_ready;
  logic [N-1:0]  O1;
  logic          O1_valid;
  logic          O1_ready;
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  demux_nto2n_stream #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .I        (I),
    .S        (S),
    .I_valid  (I_valid),
    .I_ready  (I_ready),
    .O0       (O0),
    .O0_valid (O0_valid),
    .O0_ready (O0_ready),
    .O1       (O1),
    .O1_valid (O1_valid),
    .O1_ready (O1_ready),
    .count0   (count0),
    .count1   (count1),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a live input that must not be written.
    rst = 1'b1; I = 32'hDEADBEEF; S = 1'b1; I_valid = 1'b1;
    O0_ready = 1'b1; O1_ready = 1'b1;
    #1;
    chk("rst_iready_held", {31'd0, I_ready}, 32'd0);
    tick();
    tick();
    chk("rst_O0", O0, 32'd0);
    chk("rst_O1", O1, 32'd0);
    chk("rst_O0_valid", {31'd0, O0_valid}, 32'd0);
    chk("rst_O1_valid", {31'd0, O1_valid}, 32'd0);
    chk("rst_count0", {28'd0, count0}, 32'd0);
    chk("rst_count1", {28'd0, count1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iready", {31'd0, I_ready}, 32'd0);
    rst = 1'b0; I_valid = 1'b0;
    tick();
    chk("idle_O1_valid", {31'd0, O1_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    S = 1'b1; #1;
    chk("idle_iready_s1", {31'd0, I_ready}, 32'd1);
    S = 1'b0; #1;
    chk("idle_iready_s0", {31'd0, I_ready}, 32'd1);

    // Basic routing.
    I = 32'hE59F1020; S = 1'b1; I_valid = 1'b1; #1;
    chk("route_iready", {31'd0, I_ready}, 32'd1);
    tick();
    I = 32'hE3A00000; S = 1'b0;
    chk("route_O1", O1, 32'hE59F1020);
    chk("route_O1_valid", {31'd0, O1_valid}, 32'd1);
    chk("route_O0_valid_pre", {31'd0, O0_valid}, 32'd0);
    tick();
    I_valid = 1'b0;
    chk("route_O0", O0, 32'hE3A00000);
    chk("route_O0_valid", {31'd0, O0_valid}, 32'd1);
    chk("route_O1_valid_post", {31'd0, O1_valid}, 32'd0);
    chk("route_count1", {28'd0, count1}, 32'd1);
    tick();
    chk("route_count0", {28'd0, count0}, 32'd1);
    chk("route_busy", {31'd0, busy}, 32'd0);

    // Backpressure to FULL on output 0.
    O0_ready = 1'b0;
    I = 32'h1; S = 1'b0; I_valid = 1'b1;
    tick();
    I = 32'h2;
    tick();
    I = 32'h3; #1;
    chk("bp_full_iready", {31'd0, I_ready}, 32'd0);
    chk("bp_head", O0, 32'h1);
    tick();
    chk("bp_still_full", {31'd0, I_ready}, 32'd0);
    chk("bp_hold", O0, 32'h1);
    S = 1'b1; #1;
    chk("bp_other_iready", {31'd0, I_ready}, 32'd1);
    tick();
    I_valid = 1'b0; O0_ready = 1'b1;
    chk("bp_O1", O1, 32'h3);
    chk("bp_O1_valid", {31'd0, O1_valid}, 32'd1);
    chk("bp_O0_first", O0, 32'h1);
    tick();
    chk("bp_O0_second", O0, 32'h2);
    chk("bp_O0_valid", {31'd0, O0_valid}, 32'd1);
    chk("bp_count0_a", {28'd0, count0}, 32'd2);
    chk("bp_count1", {28'd0, count1}, 32'd2);
    tick();
    chk("bp_count0_b", {28'd0, count0}, 32'd3);
    chk("bp_drained", {31'd0, O0_valid}, 32'd0);

    // Simultaneous push/pop while FIFO0 holds one word.
    O0_ready = 1'b0;
    I = 32'hA; S = 1'b0; I_valid = 1'b1;
    tick();
    I = 32'hB; O0_ready = 1'b1; #1;
    chk("pp_iready", {31'd0, I_ready}, 32'd1);
    chk("pp_headA", O0, 32'hA);
    tick();
    I_valid = 1'b0; O0_ready = 1'b0;
    chk("pp_headB", O0, 32'hB);
    chk("pp_count0", {28'd0, count0}, 32'd4);
    I = 32'hC; I_valid = 1'b1; #1;
    chk("pp_occ1_iready", {31'd0, I_ready}, 32'd1);
    tick();
    I_valid = 1'b0;
    chk("pp_occ2_full", {31'd0, I_ready}, 32'd0);
    O0_ready = 1'b1;
    tick();
    chk("pp_headC", O0, 32'hC);
    tick();
    chk("pp_count0_end", {28'd0, count0}, 32'd6);
    chk("pp_empty", {31'd0, O0_valid}, 32'd0);

    // Reset mid-stream with FIFO1 full.
    O1_ready = 1'b0;
    I = 32'h11; S = 1'b1; I_valid = 1'b1;
    tick();
    I = 32'h22;
    tick();
    I_valid = 1'b0;
    chk("mrst_head", O1, 32'h11);
    chk("mrst_full", {31'd0, I_ready}, 32'd0);
    rst = 1'b1; O1_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_O1_valid", {31'd0, O1_valid}, 32'd0);
    chk("mrst_count1", {28'd0, count1}, 32'd0);
    chk("mrst_count0", {28'd0, count0}, 32'd0);
    chk("mrst_O1", O1, 32'd0);
    tick();
    chk("mrst_stays_empty", {31'd0, O1_valid}, 32'd0);
    chk("mrst_no_ghost", O1, 32'd0);

    // Counter wrap: 17 back-to-back words to O1, consumer always ready.
    S = 1'b1; I_valid = 1'b1; O1_ready = 1'b1;
    for (int w = 1; w <= 17; w++) begin
      I = w; #1;
      chk("wrap_iready", {31'd0, I_ready}, 32'd1);
      tick();
      chk("wrap_head", O1, w);
      chk("wrap_count1", {28'd0, count1}, (w - 1) % 16);
    end
    I_valid = 1'b0;
    tick();
    chk("wrap_count1_final", {28'd0, count1}, 32'd1);
    chk("wrap_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
